// File: rtl/spi_frame_scheduler.sv
// Per-sample SPI frame sequencer: each adc_clock rising edge runs ADC read,
// DAC write and one round-robin trim-pot read over a single shared shifter.
module spi_frame_scheduler #(
    parameter int unsigned       DATA_W   = 16,
    parameter int unsigned       TRIM_W   = 8,
    parameter logic [DATA_W-1:0] ADC_CMD  = 16'h8000,
    parameter logic [DATA_W-1:0] TRIM_CMD = 16'hC000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              adc_clock,
    input  logic              enable,
    input  logic [DATA_W-1:0] dac,
    output logic              xfer_start,
    output logic [1:0]        xfer_dev,
    output logic [DATA_W-1:0] xfer_tx,
    input  logic              xfer_busy,
    input  logic              xfer_done,
    input  logic [DATA_W-1:0] xfer_rx,
    output logic [DATA_W-1:0] adc,
    output logic              adc_valid,
    output logic [TRIM_W-1:0] trim1,
    output logic [TRIM_W-1:0] trim2,
    output logic [TRIM_W-1:0] trim3,
    output logic [TRIM_W-1:0] trim4,
    output logic [1:0]        trim_mux,
    output logic              overrun,
    output logic [7:0]        overrun_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        ADC_REQ,
        ADC_WAIT,
        DAC_REQ,
        DAC_WAIT,
        TRIM_REQ,
        TRIM_WAIT
    } state_t;

    localparam logic [1:0] DEV_ADC  = 2'd0;
    localparam logic [1:0] DEV_DAC  = 2'd1;
    localparam logic [1:0] DEV_TRIM = 2'd2;

    state_t            state;
    logic              adc_clock_q;
    logic [1:0]        ch;
    logic [DATA_W-1:0] dac_q;
    logic              frame_edge;
    logic              in_req;

    assign frame_edge = adc_clock & ~adc_clock_q;
    assign in_req     = (state == ADC_REQ) || (state == DAC_REQ) || (state == TRIM_REQ);
    // Request is held off while the shifter is still busy, so it fires exactly once.
    assign xfer_start = in_req & ~xfer_busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            adc_clock_q <= 1'b1;
            ch          <= 2'd0;
            dac_q       <= '0;
            xfer_dev    <= DEV_ADC;
            xfer_tx     <= '0;
            adc         <= '0;
            adc_valid   <= 1'b0;
            trim1       <= '0;
            trim2       <= '0;
            trim3       <= '0;
            trim4       <= '0;
            trim_mux    <= 2'd0;
            overrun     <= 1'b0;
            overrun_cnt <= 8'd0;
        end else begin
            adc_clock_q <= adc_clock;
            adc_valid   <= 1'b0;

            // Edges arriving mid-frame are dropped and counted, never queued.
            if (frame_edge && (state != IDLE)) begin
                overrun <= 1'b1;
                if (overrun_cnt != 8'hFF) begin
                    overrun_cnt <= overrun_cnt + 8'd1;
                end
            end

            case (state)
                IDLE: begin
                    if (frame_edge && enable) begin
                        dac_q    <= dac;
                        trim_mux <= ch;
                        xfer_dev <= DEV_ADC;
                        xfer_tx  <= ADC_CMD;
                        state    <= ADC_REQ;
                    end
                end
                ADC_REQ: begin
                    if (!xfer_busy) state <= ADC_WAIT;
                end
                ADC_WAIT: begin
                    if (xfer_done) begin
                        adc       <= xfer_rx;
                        adc_valid <= 1'b1;
                        xfer_dev  <= DEV_DAC;
                        xfer_tx   <= dac_q;
                        state     <= DAC_REQ;
                    end
                end
                DAC_REQ: begin
                    if (!xfer_busy) state <= DAC_WAIT;
                end
                DAC_WAIT: begin
                    if (xfer_done) begin
                        xfer_dev <= DEV_TRIM;
                        xfer_tx  <= TRIM_CMD | (DATA_W'(ch) << 10);
                        state    <= TRIM_REQ;
                    end
                end
                TRIM_REQ: begin
                    if (!xfer_busy) state <= TRIM_WAIT;
                end
                TRIM_WAIT: begin
                    if (xfer_done) begin
                        case (ch)
                            2'd0:    trim1 <= xfer_rx[DATA_W-1 -: TRIM_W];
                            2'd1:    trim2 <= xfer_rx[DATA_W-1 -: TRIM_W];
                            2'd2:    trim3 <= xfer_rx[DATA_W-1 -: TRIM_W];
                            default: trim4 <= xfer_rx[DATA_W-1 -: TRIM_W];
                        endcase
                        ch    <= ch + 2'd1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
